// File: rtl/rhs_pkg.sv
// Shared opcodes, FSM states and identification ROM for the RHS2116-style SPI responder.
package rhs_pkg;

  localparam int         WORD_BITS = 32;
  localparam logic [9:0] DC_OFFSET = 10'h200;

  typedef enum logic [1:0] {
    CMD_CONVERT = 2'b00,
    CMD_CLEAR   = 2'b01,
    CMD_WRITE   = 2'b10,
    CMD_READ    = 2'b11
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_END
  } state_e;

  localparam logic [7:0]  ROM_ADDR_ID0    = 8'd251;
  localparam logic [7:0]  ROM_ADDR_ID1    = 8'd252;
  localparam logic [7:0]  ROM_ADDR_ID2    = 8'd253;
  localparam logic [7:0]  ROM_ADDR_CHIPID = 8'd255;
  localparam logic [15:0] ROM_VAL_ID0     = 16'h494E;
  localparam logic [15:0] ROM_VAL_ID1     = 16'h5441;
  localparam logic [15:0] ROM_VAL_ID2     = 16'h4E00;

  // Read-only identification space above the writable register file.
  function automatic logic [15:0] rom_value(input logic [7:0] addr, input logic [15:0] chip_id);
    case (addr)
      ROM_ADDR_ID0:    return ROM_VAL_ID0;
      ROM_ADDR_ID1:    return ROM_VAL_ID1;
      ROM_ADDR_ID2:    return ROM_VAL_ID2;
      ROM_ADDR_CHIPID: return chip_id;
      default:         return 16'h0000;
    endcase
  endfunction

endpackage

// File: rtl/rhs_spi_sync_edge.sv
// Two-flop synchronizer for one asynchronous SPI pin, with a third stage for edge detection.
module rhs_spi_sync_edge (
  input  logic clk,
  input  logic rstn,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [2:0] sync_q;

  // Clearing to 0 means a CS held low across reset never looks like a fresh frame start.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) sync_q <= 3'b000;
    else       sync_q <= {sync_q[1:0], d_i};
  end

  assign level_o = sync_q[1];
  assign rise_o  = sync_q[1] & ~sync_q[2];
  assign fall_o  = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/rhs_spi_responder.sv
// Chip-side RHS2116-style SPI responder: oversampled SPI slave, register file, ID ROM and
// deterministic CONVERT data, with replies delayed by two CS frames.
module rhs_spi_responder
  import rhs_pkg::*;
#(
  parameter logic [7:0]  STARTING_SEED = 8'd0,
  parameter int          REG_COUNT     = 64,
  parameter logic [15:0] CHIP_ID       = 16'h0020
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        SCLK,
  input  logic        CS,
  input  logic        MOSI,
  output logic        MISO,
  output logic        cmd_valid,
  output logic [31:0] cmd_word,
  output logic        frame_err,
  output logic [15:0] convert_count,
  output logic [5:0]  last_channel
);

  localparam int REG_AW = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;

  logic [2:0] pin_raw, pin_lvl, pin_rise, pin_fall;
  assign pin_raw = {MOSI, CS, SCLK};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_sync
      rhs_spi_sync_edge u_sync (
        .clk     (clk),
        .rstn    (rstn),
        .d_i     (pin_raw[gi]),
        .level_o (pin_lvl[gi]),
        .rise_o  (pin_rise[gi]),
        .fall_o  (pin_fall[gi])
      );
    end
  endgenerate

  logic sclk_rise, sclk_fall, cs_rise, cs_fall, mosi_lvl;
  assign sclk_rise = pin_rise[0];
  assign sclk_fall = pin_fall[0];
  assign cs_rise   = pin_rise[1];
  assign cs_fall   = pin_fall[1];
  assign mosi_lvl  = pin_lvl[2];

  logic sync_unused;
  assign sync_unused = ^{pin_lvl[1:0], pin_rise[2], pin_fall[2]};

  state_e      state_q, state_d;
  logic [31:0] rx_q, rx_d;
  logic [5:0]  bit_cnt_q, bit_cnt_d;
  logic        miso_q, miso_d;
  logic        decode_en, frame_err_d;
  logic        cmd_valid_q, frame_err_q;
  logic [31:0] reply0_q, reply1_q, reply_new;
  logic [31:0] cmd_word_q;
  logic [7:0]  sample_q, sample_d;
  logic [15:0] conv_cnt_q, conv_cnt_d;
  logic [5:0]  last_ch_q, last_ch_d;
  logic        wr_en;
  logic [15:0] rd_value;
  logic [15:0] regs_q [REG_COUNT];

  logic [5:0]  rx_ch;
  logic [7:0]  rx_addr, ac_tag;
  logic [15:0] rx_data;
  logic [9:0]  dc_val;
  assign rx_ch   = rx_q[21:16];
  assign rx_addr = rx_q[23:16];
  assign rx_data = rx_q[15:0];
  assign ac_tag  = STARTING_SEED + 8'(rx_ch);
  assign dc_val  = DC_OFFSET + 10'(rx_ch);

  // A CS rise landing with the last SCLK rise still shifts that bit before END counts it.
  always_comb begin
    state_d     = state_q;
    rx_d        = rx_q;
    bit_cnt_d   = bit_cnt_q;
    miso_d      = miso_q;
    decode_en   = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        miso_d = 1'b0;
        if (cs_fall) begin
          state_d   = ST_SHIFT;
          bit_cnt_d = 6'd0;
          miso_d    = reply0_q[WORD_BITS-1];
        end
      end
      ST_SHIFT: begin
        if (sclk_rise) begin
          rx_d = {rx_q[30:0], mosi_lvl};
          if (bit_cnt_q != 6'd63) bit_cnt_d = bit_cnt_q + 6'd1;
        end
        if (sclk_fall) begin
          miso_d = bit_cnt_q[5] ? 1'b0 : reply0_q[5'(WORD_BITS - 1) - bit_cnt_q[4:0]];
        end
        if (cs_rise) state_d = ST_END;
      end
      ST_END: begin
        miso_d  = 1'b0;
        state_d = ST_IDLE;
        if (bit_cnt_q == 6'(WORD_BITS)) decode_en = 1'b1;
        else                            frame_err_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rd_value = rom_value(rx_addr, CHIP_ID);
    if (int'(rx_addr) < REG_COUNT) rd_value = regs_q[rx_addr[REG_AW-1:0]];
  end

  always_comb begin
    reply_new  = 32'h0;
    sample_d   = sample_q;
    conv_cnt_d = conv_cnt_q;
    last_ch_d  = last_ch_q;
    wr_en      = 1'b0;
    if (decode_en) begin
      case (cmd_e'(rx_q[31:30]))
        CMD_CONVERT: begin
          reply_new  = {ac_tag, sample_q, 6'b0, dc_val};
          conv_cnt_d = conv_cnt_q + 16'd1;
          last_ch_d  = rx_ch;
          if (rx_ch == 6'd15) sample_d = sample_q + 8'd1;
        end
        CMD_CLEAR: sample_d = 8'd0;
        CMD_WRITE: begin
          wr_en     = (int'(rx_addr) < REG_COUNT);
          reply_new = {16'hFFFF, rx_data};
        end
        CMD_READ:  reply_new = {16'h0000, rd_value};
        default:   reply_new = 32'h0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      rx_q        <= 32'h0;
      bit_cnt_q   <= 6'd0;
      miso_q      <= 1'b0;
      cmd_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      reply0_q    <= 32'h0;
      reply1_q    <= 32'h0;
      cmd_word_q  <= 32'h0;
      sample_q    <= 8'd0;
      conv_cnt_q  <= 16'd0;
      last_ch_q   <= 6'd0;
    end else begin
      state_q     <= state_d;
      rx_q        <= rx_d;
      bit_cnt_q   <= bit_cnt_d;
      miso_q      <= miso_d;
      cmd_valid_q <= decode_en;
      frame_err_q <= frame_err_d;
      sample_q    <= sample_d;
      conv_cnt_q  <= conv_cnt_d;
      last_ch_q   <= last_ch_d;
      if (decode_en) begin
        reply0_q   <= reply1_q;
        reply1_q   <= reply_new;
        cmd_word_q <= rx_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < REG_COUNT; i++) regs_q[i] <= 16'h0;
    end else if (wr_en) begin
      regs_q[rx_addr[REG_AW-1:0]] <= rx_data;
    end
  end

  assign MISO          = miso_q;
  assign cmd_valid     = cmd_valid_q;
  assign frame_err     = frame_err_q;
  assign cmd_word      = cmd_word_q;
  assign convert_count = conv_cnt_q;
  assign last_channel  = last_ch_q;

endmodule
